// File: rtl/vid_pkg.sv
// Types and geometry helpers shared by the video timing generator and the frame fetcher.
package vid_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // One axis of raster geometry: active region, front porch, sync width, back porch.
  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
  } vid_axis_t;

  typedef enum logic [1:0] {
    EDGE_SYNC_START,
    EDGE_SYNC_END,
    EDGE_TOTAL
  } vid_edge_e;

  function automatic logic [15:0] vid_edge(vid_axis_t a, vid_edge_e e);
    logic [15:0] v;
    case (e)
      EDGE_SYNC_START: v = a.active + a.fp;
      EDGE_SYNC_END:   v = a.active + a.fp + a.sync;
      default:         v = a.active + a.fp + a.sync + a.bp;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vid_timing_px_if.sv
// Pixel stream from the frame fetcher (master) into the timing generator (slave).
interface vid_timing_px_if;
  import vid_pkg::*;

  logic pix_valid;
  rgb_t pix_data;
  logic pix_ready;

  modport master (output pix_valid, output pix_data, input pix_ready);
  modport slave  (input pix_valid, input pix_data, output pix_ready);

endinterface

// File: rtl/vid_pix_fifo.sv
// Synchronous pixel FIFO with occupancy count; read data is the head entry, valid when not empty.
module vid_pix_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/vid_timing_px.sv
// Raster timing generator: h/v counters, sync/blank decode and registered pixel output fed from the pixel FIFO.
module vid_timing_px
  import vid_pkg::*;
#(
  parameter int          H_ACTIVE   = 640,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FP       = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33,
  parameter logic        HS_POL     = 1'b0,
  parameter logic        VS_POL     = 1'b0,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [23:0] BG_RGB     = 24'h000000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  vid_timing_px_if.slave                pix,
  input  logic                          underflow_clr,
  output logic                          hsync,
  output logic                          hblank,
  output logic                          vsync,
  output logic                          vblank,
  output logic [7:0]                    R,
  output logic [7:0]                    G,
  output logic [7:0]                    B,
  output logic                          frame_start,
  output logic                          line_start,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam vid_axis_t H_AX = '{active: 16'(H_ACTIVE), fp: 16'(H_FP), sync: 16'(H_SYNC), bp: 16'(H_BP)};
  localparam vid_axis_t V_AX = '{active: 16'(V_ACTIVE), fp: 16'(V_FP), sync: 16'(V_SYNC), bp: 16'(V_BP)};

  localparam logic [15:0] H_TOTAL = vid_edge(H_AX, EDGE_TOTAL);
  localparam logic [15:0] H_SS    = vid_edge(H_AX, EDGE_SYNC_START);
  localparam logic [15:0] H_SE    = vid_edge(H_AX, EDGE_SYNC_END);
  localparam logic [15:0] V_TOTAL = vid_edge(V_AX, EDGE_TOTAL);
  localparam logic [15:0] V_SS    = vid_edge(V_AX, EDGE_SYNC_START);
  localparam logic [15:0] V_SE    = vid_edge(V_AX, EDGE_SYNC_END);

  localparam int HW = $clog2(int'(H_TOTAL));
  localparam int VW = $clog2(int'(V_TOTAL));

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [15:0]   w_h16;
  logic [15:0]   w_v16;
  logic          w_h_act;
  logic          w_v_act;
  logic          w_h_sync;
  logic          w_v_sync;
  logic          w_h_last;
  logic          w_v_last;
  logic          w_pop;

  logic          r_hsync;
  logic          r_hblank;
  logic          r_vsync;
  logic          r_vblank;
  logic          r_frame_start;
  logic          r_line_start;
  logic          r_underflow;
  rgb_t          r_rgb;

  rgb_t          w_fifo_rdata;
  logic          w_fifo_full;
  logic          w_fifo_empty;

  assign w_h16    = 16'(r_h);
  assign w_v16    = 16'(r_v);
  assign w_h_act  = (w_h16 < H_AX.active);
  assign w_v_act  = (w_v16 < V_AX.active);
  assign w_h_sync = (w_h16 >= H_SS) && (w_h16 < H_SE);
  assign w_v_sync = (w_v16 >= V_SS) && (w_v16 < V_SE);
  assign w_h_last = (w_h16 == H_TOTAL - 16'd1);
  assign w_v_last = (w_v16 == V_TOTAL - 16'd1);
  assign w_pop    = enable && w_h_act && w_v_act;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h <= '0;
      r_v <= '0;
    end else if (!enable) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_h_last) begin
      r_h <= '0;
      r_v <= w_v_last ? '0 : r_v + 1'b1;
    end else begin
      r_h <= r_h + 1'b1;
    end
  end

  vid_pix_fifo #(
    .WIDTH (24),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (pix.pix_valid),
    .i_wdata (pix.pix_data),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_count (fifo_level),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign pix.pix_ready = !w_fifo_full;

  // Outputs describe the position the counters held at the edge, so they lag the counters by one clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hsync       <= !HS_POL;
      r_vsync       <= !VS_POL;
      r_hblank      <= 1'b1;
      r_vblank      <= 1'b1;
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
      r_underflow   <= 1'b0;
      r_rgb         <= '0;
    end else begin
      r_hsync       <= (enable && w_h_sync) ? HS_POL : !HS_POL;
      r_vsync       <= (enable && w_v_sync) ? VS_POL : !VS_POL;
      r_hblank      <= !(enable && w_h_act);
      r_vblank      <= !(enable && w_v_act);
      r_frame_start <= enable && (r_h == '0) && (r_v == '0);
      r_line_start  <= enable && (r_h == '0) && w_v_act;
      if (!w_pop)            r_rgb <= '0;
      else if (w_fifo_empty) r_rgb <= BG_RGB;
      else                   r_rgb <= w_fifo_rdata;
      // A fresh underflow outranks a clear arriving in the same cycle.
      if (w_pop && w_fifo_empty) r_underflow <= 1'b1;
      else if (underflow_clr)    r_underflow <= 1'b0;
    end
  end

  assign hsync       = r_hsync;
  assign hblank      = r_hblank;
  assign vsync       = r_vsync;
  assign vblank      = r_vblank;
  assign frame_start = r_frame_start;
  assign line_start  = r_line_start;
  assign underflow   = r_underflow;
  assign R           = r_rgb.r;
  assign G           = r_rgb.g;
  assign B           = r_rgb.b;

endmodule

// File: tb/tb_vid_timing_px.sv
// Bench for vid_timing_px on a 8x6 raster with a 4-deep FIFO; a second instance covers active-high syncs.
module tb_vid_timing_px;

  localparam logic [23:0] BG = 24'hABCDEF;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic underflow_clr = 1'b0;
  always #5 clk = ~clk;

  vid_timing_px_if pif0 ();
  vid_timing_px_if pif1 ();

  logic hsync, hblank, vsync, vblank, frame_start, line_start, underflow;
  logic [7:0] r, g, b;
  logic [2:0] fifo_level;
  logic hsync1, hblank1, vsync1, vblank1, fs1, ls1, uf1;
  logic [7:0] r1, g1, b1;
  logic [2:0] lvl1;

  vid_timing_px #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .FIFO_DEPTH(4), .BG_RGB(BG)
  ) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .pix(pif0.slave),
    .underflow_clr(underflow_clr),
    .hsync(hsync), .hblank(hblank), .vsync(vsync), .vblank(vblank),
    .R(r), .G(g), .B(b),
    .frame_start(frame_start), .line_start(line_start), .underflow(underflow),
    .fifo_level(fifo_level)
  );

  vid_timing_px #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .FIFO_DEPTH(4), .BG_RGB(BG)
  ) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .pix(pif1.slave),
    .underflow_clr(underflow_clr),
    .hsync(hsync1), .hblank(hblank1), .vsync(vsync1), .vblank(vblank1),
    .R(r1), .G(g1), .B(b1),
    .frame_start(fs1), .line_start(ls1), .underflow(uf1),
    .fifo_level(lvl1)
  );

  int total = 0;
  int bad = 0;

  // Reference model: raster position about to be emitted, FIFO scoreboard, sticky underflow.
  logic [23:0] q[$];
  int m_h = 0;
  int m_v = 0;
  logic e_uf = 1'b0;
  logic [6:0] e_tim;
  logic [23:0] e_rgb;
  logic [1:0] e_sync1;

  wire [6:0]  o_tim = {hsync, hblank, vsync, vblank, frame_start, line_start, underflow};
  wire [23:0] o_rgb = {r, g, b};

  task automatic tick();
    logic hact, vact, act, hs, vs, acc;
    hact = enable && (m_h < 4);
    vact = enable && (m_v < 3);
    act  = hact && vact;
    hs   = enable && (m_h >= 5) && (m_h < 7);
    vs   = enable && (m_v == 4);
    acc  = pif0.pix_valid && (q.size() < 4);
    e_rgb = 24'h0;
    if (act && q.size() == 0) begin
      e_rgb = BG;
      e_uf  = 1'b1;
    end else begin
      if (act) e_rgb = q.pop_front();
      if (underflow_clr) e_uf = 1'b0;
    end
    if (acc) q.push_back(pif0.pix_data);
    e_tim   = {~hs, ~hact, ~vs, ~vact, enable && m_h == 0 && m_v == 0, enable && m_h == 0 && m_v < 3, e_uf};
    e_sync1 = {hs, vs};
    if (!enable) begin
      m_h = 0;
      m_v = 0;
    end else if (m_h == 7) begin
      m_h = 0;
      m_v = (m_v == 5) ? 0 : m_v + 1;
    end else begin
      m_h = m_h + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    m_h  = 0;
    m_v  = 0;
    e_uf = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    pif0.pix_valid = 1'b0;
    pif0.pix_data  = 24'h0;
    pif1.pix_valid = 1'b0;
    pif1.pix_data  = 24'h0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++; if (o_tim !== 7'b1111000) begin bad++; $display("FAIL reset_timing got=%b exp=%b", o_tim, 7'b1111000); end
    total++; if (o_rgb !== 24'h0) begin bad++; $display("FAIL reset_rgb got=%h exp=000000", o_rgb); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    total++; if (pif0.pix_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", pif0.pix_ready); end
    total++; if ({hsync1, vsync1, hblank1, vblank1} !== 4'b0011) begin bad++; $display("FAIL reset_pol1 got=%b exp=0011", {hsync1, vsync1, hblank1, vblank1}); end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_timing();
    int nxt = 1;
    int last_fs = -1;
    int fs_cnt = 0;
    enable = 1'b0;
    pif0.pix_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pif0.pix_data = 24'(nxt);
      if (q.size() < 4) nxt++;
      tick();
    end
    total++; if (fifo_level !== 3'd4 || pif0.pix_ready !== 1'b0) begin bad++; $display("FAIL prefill got lvl=%0d rdy=%b exp lvl=4 rdy=0", fifo_level, pif0.pix_ready); end
    enable = 1'b1;
    for (int c = 0; c < 96; c++) begin
      pif0.pix_data = 24'(nxt);
      if (q.size() < 4) nxt++;
      tick();
      total++; if (o_tim !== e_tim) begin bad++; $display("FAIL timing c=%0d got=%b exp=%b", c, o_tim, e_tim); end
      total++; if (o_rgb !== e_rgb) begin bad++; $display("FAIL timing_rgb c=%0d got=%h exp=%h", c, o_rgb, e_rgb); end
      total++; if (fifo_level !== 3'(q.size())) begin bad++; $display("FAIL timing_level c=%0d got=%0d exp=%0d", c, fifo_level, q.size()); end
      total++; if ({hsync1, vsync1} !== e_sync1) begin bad++; $display("FAIL timing_pol1 c=%0d got=%b exp=%b", c, {hsync1, vsync1}, e_sync1); end
      if (frame_start === 1'b1) begin
        fs_cnt++;
        if (last_fs >= 0) begin
          total++; if (c - last_fs != 48) begin bad++; $display("FAIL frame_period got=%0d exp=48", c - last_fs); end
        end
        last_fs = c;
      end
    end
    total++; if (fs_cnt != 2) begin bad++; $display("FAIL frame_count got=%0d exp=2", fs_cnt); end
  endtask

  task automatic test_pixels();
    int nxt = 1;
    int ridx = 1;
    do_reset();
    enable = 1'b0;
    pif0.pix_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pif0.pix_data = 24'(nxt);
      if (q.size() < 4) nxt = (nxt == 12) ? 1 : nxt + 1;
      tick();
    end
    enable = 1'b1;
    for (int c = 0; c < 96; c++) begin
      pif0.pix_data = 24'(nxt);
      if (q.size() < 4) nxt = (nxt == 12) ? 1 : nxt + 1;
      tick();
      total++; if (o_rgb !== e_rgb) begin bad++; $display("FAIL pixel_sb c=%0d got=%h exp=%h", c, o_rgb, e_rgb); end
      total++; if (o_tim !== e_tim) begin bad++; $display("FAIL pixel_timing c=%0d got=%b exp=%b", c, o_tim, e_tim); end
      if (e_tim[5] == 1'b0 && e_tim[3] == 1'b0) begin
        total++; if (o_rgb !== 24'(ridx)) begin bad++; $display("FAIL raster_order c=%0d got=%h exp=%h", c, o_rgb, 24'(ridx)); end
        ridx = (ridx == 12) ? 1 : ridx + 1;
      end
    end
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL pixel_no_underflow got=%b exp=0", underflow); end
  endtask

  task automatic test_underflow();
    pif0.pix_valid = 1'b0;
    for (int i = 0; i < 100 && !(m_v == 3 && m_h == 0); i++) begin
      tick();
      total++; if (o_rgb !== e_rgb) begin bad++; $display("FAIL uf_rgb i=%0d got=%h exp=%h", i, o_rgb, e_rgb); end
      total++; if (o_tim !== e_tim) begin bad++; $display("FAIL uf_timing i=%0d got=%b exp=%b", i, o_tim, e_tim); end
    end
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL uf_set got=%b exp=1", underflow); end
    underflow_clr = 1'b1;
    tick();
    underflow_clr = 1'b0;
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL uf_clear_blank got=%b exp=0", underflow); end
    for (int i = 0; i < 100 && !(m_v == 0 && m_h == 0); i++) begin
      tick();
      total++; if (o_tim !== e_tim) begin bad++; $display("FAIL uf_idle i=%0d got=%b exp=%b", i, o_tim, e_tim); end
    end
    underflow_clr = 1'b1;
    tick();
    underflow_clr = 1'b0;
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL uf_clear_vs_new got=%b exp=1", underflow); end
    total++; if (o_rgb !== BG) begin bad++; $display("FAIL uf_bg got=%h exp=%h", o_rgb, BG); end
  endtask

  task automatic test_fifo_full();
    do_reset();
    enable = 1'b0;
    pif0.pix_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pif0.pix_data = 24'h000100 + 24'(i);
      tick();
    end
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL full_level got=%0d exp=4", fifo_level); end
    total++; if (pif0.pix_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", pif0.pix_ready); end
    pif0.pix_data = 24'h0001FF;
    tick();
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL full_reject got=%0d exp=4", fifo_level); end
    pif0.pix_valid = 1'b0;
    enable = 1'b1;
    tick();
    total++; if (o_rgb !== 24'h000100) begin bad++; $display("FAIL full_pop0 got=%h exp=000100", o_rgb); end
    tick();
    total++; if (fifo_level !== 3'd2) begin bad++; $display("FAIL level_two got=%0d exp=2", fifo_level); end
    pif0.pix_valid = 1'b1;
    pif0.pix_data  = 24'h000200;
    tick();
    pif0.pix_valid = 1'b0;
    total++; if (fifo_level !== 3'd2) begin bad++; $display("FAIL push_pop_level got=%0d exp=2", fifo_level); end
    total++; if (o_rgb !== 24'h000102) begin bad++; $display("FAIL push_pop_rgb got=%h exp=000102", o_rgb); end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (o_rgb !== e_rgb) begin bad++; $display("FAIL drain i=%0d got=%h exp=%h", i, o_rgb, e_rgb); end
    end
  endtask

  task automatic test_polarity();
    int hs_hi = 0;
    int vs_hi = 0;
    do_reset();
    total++; if (hsync1 !== 1'b0 || vsync1 !== 1'b0) begin bad++; $display("FAIL pol_reset got=%b%b exp=00", hsync1, vsync1); end
    enable = 1'b1;
    for (int c = 0; c < 48; c++) begin
      tick();
      total++; if ({hsync1, vsync1} !== e_sync1) begin bad++; $display("FAIL pol_sync c=%0d got=%b exp=%b", c, {hsync1, vsync1}, e_sync1); end
      if (hsync1 === 1'b1) hs_hi++;
      if (vsync1 === 1'b1) vs_hi++;
    end
    total++; if (hs_hi != 12) begin bad++; $display("FAIL pol_hs_count got=%0d exp=12", hs_hi); end
    total++; if (vs_hi != 8) begin bad++; $display("FAIL pol_vs_count got=%0d exp=8", vs_hi); end
  endtask

  task automatic test_enable_reset();
    pif0.pix_valid = 1'b0;
    for (int i = 0; i < 100 && !(m_v == 1 && m_h == 2); i++) tick();
    enable = 1'b0;
    tick();
    total++; if (o_tim[6:1] !== 6'b111100) begin bad++; $display("FAIL en_low_timing got=%b exp=111100", o_tim[6:1]); end
    total++; if (o_rgb !== 24'h0) begin bad++; $display("FAIL en_low_rgb got=%h exp=000000", o_rgb); end
    enable = 1'b1;
    tick();
    total++; if ({frame_start, line_start, hblank, vblank} !== 4'b1100) begin bad++; $display("FAIL en_restart got=%b exp=1100", {frame_start, line_start, hblank, vblank}); end
    pif0.pix_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pif0.pix_data = 24'h000300 + 24'(i);
      tick();
      total++; if (fifo_level !== 3'(q.size())) begin bad++; $display("FAIL pre_reset_level i=%0d got=%0d exp=%0d", i, fifo_level, q.size()); end
      total++; if (o_rgb !== e_rgb) begin bad++; $display("FAIL pre_reset_rgb i=%0d got=%h exp=%h", i, o_rgb, e_rgb); end
    end
    pif0.pix_valid = 1'b0;
    reset = 1'b1;
    #2;
    total++; if (o_tim !== 7'b1111000) begin bad++; $display("FAIL async_reset_timing got=%b exp=1111000", o_tim); end
    total++; if (o_rgb !== 24'h0 || fifo_level !== 3'd0) begin bad++; $display("FAIL async_reset_data got rgb=%h lvl=%0d exp 000000/0", o_rgb, fifo_level); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    tick();
    total++; if (frame_start !== 1'b1 || o_rgb !== BG) begin bad++; $display("FAIL post_reset got fs=%b rgb=%h exp fs=1 rgb=%h", frame_start, o_rgb, BG); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_pixels();
    test_underflow();
    test_fifo_full();
    test_polarity();
    test_enable_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vid_timing_px.md
# vid_timing_px

Parametrised video timing generator with pixel FIFO; the next generation of our video output block. It produces hsync/hblank/vsync/vblank from configurable porch/sync geometry and programmable sync polarity. It streams 24-bit pixels from an upstream fetch engine through an internal FIFO to the R/G/B outputs. It sits between the bus-mastering frame fetcher and the display PHY.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 1'b0, active level of hsync
- VS_POL, 1'b0, active level of vsync
- FIFO_DEPTH, 16, pixel FIFO entries (power of two, ≥2)
- BG_RGB, 24'h000000, colour driven on underflow
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run timing; low holds counters at (0,0)
- pix_valid  in  1  upstream pixel valid
- pix_data  in  24  {R,G,B}, R in [23:16]
- pix_ready  out  1  FIFO not full
- underflow_clr  in  1  clears sticky underflow
- hsync, hblank, vsync, vblank  out  1 each  timing outputs
- R, G, B  out  8 each  pixel colour, 0 when blanked
- frame_start  out  1  one-cycle pulse at position (0,0)
- line_start  out  1  one-cycle pulse at h=0 of each active line
- underflow  out  1  sticky: active pixel had empty FIFO
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. hcount is 0..H_TOTAL-1; it wraps to 0 and increments vcount. vcount wraps at V_TOTAL-1.
- Horizontal active when hcount < H_ACTIVE. Sync asserted when H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC. The vertical axis uses the same rules on vcount.
- hblank = !h_active; vblank = !v_active; hsync/vsync are driven to HS_POL/VS_POL when in sync, else to the inverse.
- Push: pix_valid && pix_ready writes pix_data. pix_ready = !full, registered-free (comb from count).
- Pop: one entry per cycle whenever h_active && v_active && enable. If the FIFO is empty at a pop, drive BG_RGB, set underflow, and leave the FIFO unchanged. There is no push→pop bypass: a push to an empty FIFO in the same cycle as a pop still underflows.
- Simultaneous push and pop with non-empty FIFO: level unchanged.
- underflow_clr clears underflow; a new underflow in the same cycle wins (stays 1).
- enable low: counters are forced to (0,0), no pops, blanks = 1, syncs inactive, RGB = 0, pulses = 0. The FIFO still accepts pushes.
- Reset: hcount = vcount = 0, FIFO empty, hsync = !HS_POL, vsync = !VS_POL, hblank = vblank = 1, R = G = B = 0, frame_start = line_start = underflow = 0, fifo_level = 0. Reset mid-frame discards FIFO contents.

## Timing
- All outputs except pix_ready and fifo_level are registered. Outputs for counter position (h,v) appear one clock after the counters hold (h,v).
- Pixel latency: a popped entry reaches R/G/B on the same edge that its position's timing outputs update.
- The first active position after enable rises is (0,0), emitted one clock after enable is sampled high.
- frame_start is aligned with hblank=0/vblank=0 of pixel (0,0). line_start is aligned with pixel (0,v) for v < V_ACTIVE.
- fifo_level updates the cycle after a push or pop.

## Structure
- Package vid_pkg: rgb_t packed struct {r,g,b}, a timing parameter struct, and a helper function for the total/sync-edge constants. Put these in the package because the fetcher shares them.
- Sub-module vid_pix_fifo: synchronous FIFO with count, full, and empty, parametrised by width and depth. It is instantiated once. The counters, decode, and output registers stay in the top.

## Test plan
Small geometry for all scenarios: H 4/1/2/1, V 3/1/1/1, FIFO_DEPTH 4, pols 0.
- Reset then enable with FIFO kept full → per line: hblank 0 for 4 clocks, hsync low at h=5..6; vsync low on line 4; period 48 clocks; frame_start every 48.
- Push 12 pixels 0x000001..0x00000C ahead of each frame → RGB outputs 1..12 in raster order and 0 during blanking; underflow stays 0.
- Leave the FIFO empty → every active pixel shows BG_RGB and underflow=1. Assert underflow_clr with no active pixel → 0. Assert it in the same cycle as a new underflow → stays 1.
- Fill the FIFO to 4 → pix_ready=0 and fifo_level=4. Push+pop the same cycle at level 2 → level stays 2.
- Set HS_POL=1, VS_POL=1 → syncs idle low and pulse high; reset value hsync=0.
- Drop enable mid-line, then assert reset mid-frame → enable low gives blanks=1, counters restart at (0,0). Reset gives the listed reset values and fifo_level=0.
